// File: rtl/floo_vc_router_pkg.sv
// Shared types for the VC router: switch-allocation output FSM encoding and
// the credit counter width helper.
package floo_vc_router_pkg;

    typedef enum logic [0:0] {
        SaOutIdle   = 1'b0,
        SaOutLocked = 1'b1
    } sa_out_state_e;

    function automatic int unsigned credit_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/floo_credit_counter.sv
// Credit counter for one downstream VC. It starts full (Depth free slots) and
// saturates at Depth, so a spurious extra return cannot manufacture a slot.
module floo_credit_counter
    import floo_vc_router_pkg::*;
#(
    parameter int unsigned Depth    = 3,
    parameter int unsigned CntWidth = credit_cnt_width(Depth)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc,
    input  logic dec,
    output logic nonzero
);

    localparam logic [CntWidth-1:0] Full = CntWidth'(Depth);

    logic [CntWidth-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= Full;
        end else if (inc && !dec) begin
            if (cnt != Full) cnt <= cnt + CntWidth'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - CntWidth'(1);
        end
    end

    assign nonzero = |cnt;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(inc && !dec && cnt == Full));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(dec && !inc && cnt == '0));

endmodule

// File: rtl/floo_sa_output_credit.sv
// Output-port switch allocation: round-robin among requesting inputs, wormhole
// lock until the last flit, and per-VC downstream credit tracking.
module floo_sa_output_credit
    import floo_vc_router_pkg::*;
#(
    parameter int unsigned NumInputs = 5,
    parameter int unsigned NumVC     = 4,
    parameter int unsigned VCDepth   = 3,
    parameter int unsigned VcIdWidth = $clog2(NumVC),
    parameter int unsigned CntWidth  = credit_cnt_width(VCDepth),
    parameter int unsigned InIdWidth = $clog2(NumInputs)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumInputs-1:0]                req_i,
    input  logic [NumInputs-1:0][VcIdWidth-1:0] req_vc_id_i,
    input  logic [NumInputs-1:0]                req_last_i,
    output logic [NumInputs-1:0]                grant_o,
    output logic [InIdWidth-1:0]                grant_id_o,
    output logic                                out_valid_o,
    output logic [VcIdWidth-1:0]                out_vc_id_o,
    output logic                                out_last_o,
    input  logic                                credit_v_i,
    input  logic [VcIdWidth-1:0]                credit_id_i,
    output logic [NumVC-1:0]                    credit_avail_o,
    output logic                                locked_o
);

    sa_out_state_e          state;
    logic [InIdWidth-1:0]   rr_ptr;
    logic [InIdWidth-1:0]   lock_in;
    logic [VcIdWidth-1:0]   lock_vc;
    logic [NumVC-1:0]       cred_nz;

    logic                   win_valid;
    logic [InIdWidth-1:0]   win_id;
    logic [VcIdWidth-1:0]   win_vc;
    logic                   win_last;
    logic [InIdWidth:0]     idx_w;
    logic [InIdWidth-1:0]   idx;

    // Grants are masked during reset so nothing leaves the port.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        idx_w     = '0;
        idx       = '0;
        if (!rst_i) begin
            if (state == SaOutLocked) begin
                if (req_i[lock_in] && cred_nz[lock_vc]) begin
                    win_valid = 1'b1;
                    win_id    = lock_in;
                end
            end else begin
                for (int k = 0; k < NumInputs; k++) begin
                    idx_w = {1'b0, rr_ptr} + (InIdWidth+1)'(k);
                    if (idx_w >= (InIdWidth+1)'(NumInputs))
                        idx_w = idx_w - (InIdWidth+1)'(NumInputs);
                    idx = idx_w[InIdWidth-1:0];
                    if (!win_valid && req_i[idx] && cred_nz[req_vc_id_i[idx]]) begin
                        win_valid = 1'b1;
                        win_id    = idx;
                    end
                end
            end
        end
    end

    // Credit accounting follows the latched VC while locked.
    assign win_vc   = (state == SaOutLocked) ? lock_vc : req_vc_id_i[win_id];
    assign win_last = req_last_i[win_id];

    assign grant_o     = win_valid ? (NumInputs'(1) << win_id) : '0;
    assign grant_id_o  = win_id;
    assign out_valid_o = win_valid;
    assign out_vc_id_o = win_valid ? req_vc_id_i[win_id] : '0;
    assign out_last_o  = win_valid & win_last;

    for (genvar v = 0; v < NumVC; v++) begin : g_cred
        floo_credit_counter #(
            .Depth    (VCDepth),
            .CntWidth (CntWidth)
        ) i_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .inc     (credit_v_i && credit_id_i == VcIdWidth'(v)),
            .dec     (win_valid && win_vc == VcIdWidth'(v)),
            .nonzero (cred_nz[v])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= SaOutIdle;
            rr_ptr  <= '0;
            lock_in <= '0;
            lock_vc <= '0;
        end else if (win_valid) begin
            if (win_last) begin
                state  <= SaOutIdle;
                rr_ptr <= (win_id == InIdWidth'(NumInputs-1)) ? '0 : win_id + InIdWidth'(1);
            end else if (state == SaOutIdle) begin
                state   <= SaOutLocked;
                lock_in <= win_id;
                lock_vc <= req_vc_id_i[win_id];
            end
        end
    end

    assign credit_avail_o = cred_nz;
    assign locked_o       = (state == SaOutLocked);

    a_lock_vc_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        !(state == SaOutLocked && req_i[lock_in] && req_vc_id_i[lock_in] != lock_vc));

endmodule

// File: tb/tb_floo_sa_output_credit.sv
// Bench for floo_sa_output_credit: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_floo_sa_output_credit;

    localparam int N = 5;
    localparam int V = 4;
    localparam int D = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req, last;
    logic [N-1:0][1:0] vcid;
    logic             cv;
    logic [1:0]       cid;
    logic [N-1:0]     grant;
    logic [2:0]       grant_id;
    logic             out_valid;
    logic [1:0]       out_vc;
    logic             out_last;
    logic [V-1:0]     avail;
    logic             locked;

    floo_sa_output_credit dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_vc_id_i(vcid), .req_last_i(last),
        .grant_o(grant), .grant_id_o(grant_id), .out_valid_o(out_valid),
        .out_vc_id_o(out_vc), .out_last_o(out_last), .credit_v_i(cv),
        .credit_id_i(cid), .credit_avail_o(avail), .locked_o(locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_cred[V];
    bit m_locked;
    int m_lock_in, m_lock_vc, m_rr;

    // DUT values sampled in the most recent cycle
    bit         obs_valid;
    int         obs_id;
    logic [V-1:0] obs_avail;
    bit         obs_locked;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < V; v++) m_cred[v] = D;
        m_locked = 0; m_lock_in = 0; m_lock_vc = 0; m_rr = 0;
    endtask

    task automatic model_grant(output bit gv, output int gid);
        gv = 0; gid = 0;
        if (rst) return;
        if (m_locked) begin
            if (req[m_lock_in] && m_cred[m_lock_vc] > 0) begin gv = 1; gid = m_lock_in; end
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (!gv && req[i] && m_cred[vcid[i]] > 0) begin gv = 1; gid = i; end
            end
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are sampled
    // 3 units later, then the model steps across the next edge.
    task automatic tick();
        bit ev; int eid; int evc; bit elast; logic [V-1:0] eav;
        #3;
        model_grant(ev, eid);
        evc   = ev ? int'(vcid[eid]) : 0;
        elast = ev ? last[eid] : 1'b0;
        for (int v = 0; v < V; v++) eav[v] = (m_cred[v] != 0);
        chk("grant_o",        32'(grant),     ev ? 32'(1 << eid) : 32'd0);
        chk("grant_id_o",     32'(grant_id),  32'(eid));
        chk("out_valid_o",    32'(out_valid), 32'(ev));
        chk("out_vc_id_o",    32'(out_vc),    32'(evc));
        chk("out_last_o",     32'(out_last),  32'(elast));
        chk("credit_avail_o", 32'(avail),     32'(eav));
        chk("locked_o",       32'(locked),    32'(m_locked));
        obs_valid = out_valid; obs_id = int'(grant_id); obs_avail = avail; obs_locked = locked;
        if (rst) begin
            model_reset();
        end else begin
            if (ev) m_cred[m_locked ? m_lock_vc : evc]--;
            if (cv) m_cred[cid]++;
            if (ev) begin
                if (elast) begin
                    m_locked = 0; m_rr = (eid + 1) % N;
                end else if (!m_locked) begin
                    m_locked = 1; m_lock_in = eid; m_lock_vc = evc;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_in();
        req = '0; last = '0; vcid = '0; cv = 1'b0; cid = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        chk("reset_no_grant", 32'(obs_valid), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // 1: inputs 1 and 2 on VC0 single-flit packets until VC0 runs dry
        req = 5'b00110; last = 5'b11111;
        tick(); chk("t1_g0", 32'(obs_id), 32'd1);
        chk("t1_reset_avail", 32'(obs_avail), 32'hF);
        chk("t1_reset_locked", 32'(obs_locked), 32'd0);
        tick(); chk("t1_g1", 32'(obs_id), 32'd2);
        tick(); chk("t1_g2", 32'(obs_id), 32'd1);
        tick(); chk("t1_none", 32'(obs_valid), 32'd0);
        chk("t1_avail0", 32'(obs_avail[0]), 32'd0);

        // 2: 3-flit packet from input 0 on VC2 blocks input 3
        do_reset();
        req = 5'b01001; vcid[0] = 2'd2; vcid[3] = 2'd1; last = 5'b01000;
        tick(); chk("t2_f1", 32'(obs_id), 32'd0); chk("t2_lk1", 32'(obs_locked), 32'd0);
        tick(); chk("t2_f2", 32'(obs_id), 32'd0); chk("t2_lk2", 32'(obs_locked), 32'd1);
        last[0] = 1'b1;
        tick(); chk("t2_f3", 32'(obs_id), 32'd0); chk("t2_lk3", 32'(obs_locked), 32'd1);
        tick(); chk("t2_in3", 32'(obs_id), 32'd3); chk("t2_lk4", 32'(obs_locked), 32'd0);

        // 3: lock on input 2 stalls on VC1 credit, resumes one cycle after return
        do_reset();
        clear_in();
        req = 5'b00101; vcid[2] = 2'd1; vcid[0] = 2'd0; last = 5'b00001;
        m_rr = 0;
        tick(); chk("t3_first", 32'(obs_id), 32'd0);
        tick(); chk("t3_g1", 32'(obs_id), 32'd2);
        tick(); chk("t3_g2", 32'(obs_id), 32'd2);
        tick(); chk("t3_g3", 32'(obs_id), 32'd2);
        cv = 1'b1; cid = 2'd1;
        tick(); chk("t3_stall", 32'(obs_valid), 32'd0); chk("t3_lk_stall", 32'(obs_locked), 32'd1);
        cv = 1'b0; last[2] = 1'b1;
        tick(); chk("t3_resume", 32'(obs_valid), 32'd1); chk("t3_resume_id", 32'(obs_id), 32'd2);
        chk("t3_lk_resume", 32'(obs_locked), 32'd1);

        // 4: same-cycle grant and return on VC3
        do_reset();
        req = 5'b10000; vcid[4] = 2'd3; last = 5'b10000;
        tick(); tick();
        cv = 1'b1; cid = 2'd3;
        tick(); chk("t4_g", 32'(obs_valid), 32'd1);
        cv = 1'b0;
        tick(); chk("t4_again", 32'(obs_valid), 32'd1); chk("t4_avail3", 32'(obs_avail[3]), 32'd1);
        req = '0;
        tick(); chk("t4_empty", 32'(obs_avail[3]), 32'd0);

        // 5: reset while locked restores pointer, credits and lock
        do_reset();
        req = 5'b00100; last = 5'b00100;
        tick(); chk("t5_single", 32'(obs_id), 32'd2);
        req = 5'b00010; last = 5'b00000;
        tick(); tick(); chk("t5_lock", 32'(obs_id), 32'd1);
        do_reset();
        req = 5'b01010; last = 5'b01010; vcid[1] = 2'd1; vcid[3] = 2'd1;
        tick();
        chk("t5_rr0", 32'(obs_id), 32'd1);
        chk("t5_avail", 32'(obs_avail), 32'hF);
        chk("t5_unlocked", 32'(obs_locked), 32'd0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            req = N'($urandom());
            for (int i = 0; i < N; i++) begin
                vcid[i] = 2'($urandom_range(0, V-1));
                last[i] = ($urandom_range(0, 2) == 0);
            end
            if (m_locked) vcid[m_lock_in] = 2'(m_lock_vc);
            cid = 2'($urandom_range(0, V-1));
            cv  = ($urandom_range(0, 1) == 1) && (m_cred[cid] < D);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/floo_sa_output_credit.md
# floo_sa_output_credit

Output-port half of the virtual-channel router's switch allocation. Each input port's local allocator has already picked one VC and raised a one-hot request towards a single output direction. This block sits at one output port and does three things: it round-robin arbitrates among the requesting input ports, holds a wormhole lock until the granted packet's last flit, and keeps per-VC credit counters for the downstream input buffers. A request can only be granted when the downstream VC it targets has at least one free slot.

## Interface
- NumInputs, 5, input ports that can request this output
- NumVC, 4, virtual channels on the downstream link
- VCDepth, 3, buffer slots per downstream VC (initial credit count)
- VcIdWidth, $clog2(NumVC), VC index width
- CntWidth, $clog2(VCDepth+1), credit counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  NumInputs  input i requests this output this cycle
- req_vc_id_i  in  NumInputs×VcIdWidth  downstream VC targeted by input i's flit
- req_last_i  in  NumInputs  input i's flit is the packet's last
- grant_o  out  NumInputs  one-hot grant, all 0 when no grant
- grant_id_o  out  $clog2(NumInputs)  index of granted input, 0 when none
- out_valid_o  out  1  a flit traverses this output this cycle
- out_vc_id_o  out  VcIdWidth  VC of the traversing flit
- out_last_o  out  1  the traversing flit is last
- credit_v_i  in  1  downstream freed one slot
- credit_id_i  in  VcIdWidth  VC of the returned credit
- credit_avail_o  out  NumVC  registered; bit v = credit[v] != 0
- locked_o  out  1  registered; wormhole lock held

## Operation
- Credit counters: one per VC, reset value VCDepth.
  - Decrement on grant to VC v.
  - Increment on credit_v_i with credit_id_i = v.
  - Grant and return to the same VC in the same cycle leave the counter unchanged.
  - A return while the counter equals VCDepth is an assertion error; the counter holds.
- Eligibility: input i is eligible iff req_i[i] and credit[req_vc_id_i[i]] != 0.
- FSM states:
  - IDLE: grant the first eligible input at or after rr_ptr, wrapping modulo NumInputs. If the granted flit has !last, move to LOCKED and latch lock_in = winner and lock_vc = its VC.
  - LOCKED: only lock_in is eligible; all other requests are ignored even when they have credit. If lock_in has no credit or no request, there is no grant and the state stays LOCKED. A granted flit with last returns the FSM to IDLE.
- rr_ptr:
  - Updates only when a last flit is granted: rr_ptr ← winner+1, wrapping to 0 after NumInputs-1.
  - A single-flit packet granted in IDLE therefore also advances the pointer.
- While LOCKED, req_vc_id_i[lock_in] ≠ lock_vc is an assertion error; the block still uses lock_vc for credit accounting.
- out_valid_o = |grant_o. out_vc_id_o and out_last_o take the granted input's values and are 0 when there is no grant.
- Reset values:
  - Registered state: FSM IDLE, rr_ptr 0, lock_in 0, lock_vc 0, all credits VCDepth.
  - Registered outputs: credit_avail_o all 1s, locked_o 0.
  - Combinational outputs are 0 while rst_i is high, because grants are masked during reset.
- Reset asserted mid-packet drops the lock immediately. The upstream side is responsible for packet integrity.

## Timing
- grant_o, grant_id_o, out_* are combinational from req_* and registered state, so the latency from request to grant is 0 cycles.
- Credit, FSM, rr_ptr and lock state update on the rising edge after a grant or credit return.
- A credit returned in cycle t makes its VC eligible in cycle t+1; there is no same-cycle bypass.
- credit_avail_o and locked_o reflect the post-edge state, one cycle after the causing event.
- Maximum throughput is one flit per cycle when credits are sufficient.

## Structure
- Shared package floo_vc_router_pkg holds:
  - the FSM enum sa_out_state_e {SaOutIdle, SaOutLocked}
  - a helper function computing credit counter width
- Sub-module floo_credit_counter holds one VC's counter:
  - inputs inc, dec
  - output nonzero
  - parameter Depth
  - instantiated NumVC times.
- Round-robin selection is implemented inline. The existing arbiter uses a different reset style and is not reused.

## Test plan
- Reset, then req_i=5'b00110 both to VC0, last=1, held for 3 cycles → grants are input 1, 2, 1; credit[0] goes 3→0; the 4th cycle has no grant and credit_avail_o[0]=0.
- Input 0 sends a 3-flit packet (last on flit 3) on VC2 while input 3 requests continuously with credit → input 3 gets no grant until input 0's last flit is granted; locked_o=1 for 2 cycles.
- Credits for VC1 exhausted in LOCKED on input 2, then credit_v_i=1, credit_id_i=1 → grant resumes exactly one cycle later; the lock is held throughout.
- Same-cycle grant on VC3 and credit return on VC3 with credit[3]=1 → credit[3] stays 1 and the next cycle can grant again.
- rst_i asserted while LOCKED with credit[0]=1 → next cycle shows IDLE, rr_ptr=0, all credits 3, locked_o=0.
- Credit returned to VC0 while credit[0]=3 → assertion fires and the counter stays at 3.
